// File: rtl/wave_generator_if.sv
// Sample stream between the wave generator and its sink.
//   data  : sample value
//   first : high on the first sample of each waveform period
//   valid : sample valid (source)
//   ready : sink ready (sink)
// master = generator side, slave = sink side.
interface wave_generator_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] data;
    logic                  first;
    logic                  valid;
    logic                  ready;

    modport master (output data, output first, output valid, input ready);
    modport slave  (input data, input first, input valid, output ready);
endinterface

// File: rtl/wave_generator.sv
// Runtime-configurable waveform generator (saw-up, saw-down, triangle, square)
// with a valid/ready output stream and double-buffered configuration that is
// only applied on a period boundary.
//   clk_i, a_rst_n_i   : clock, async active-low reset
//   enable_i           : run request (level)
//   cfg_load_i         : pulse, captures cfg_* into the pending config
//   cfg_mode_i         : 0 saw_p, 1 saw_n, 2 tri, 3 square
//   cfg_step_i/min/max : increment and bounds
//   cfg_high_len_i/low_len_i : square phase lengths (0 acts as 1)
//   cfg_err_o          : sticky reject flag, cleared by the next accepted load
//   m                  : output sample stream (master)
module wave_generator #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  a_rst_n_i,
    input  logic                  enable_i,
    input  logic                  cfg_load_i,
    input  logic [1:0]            cfg_mode_i,
    input  logic [DATA_WIDTH-1:0] cfg_step_i,
    input  logic [DATA_WIDTH-1:0] cfg_min_i,
    input  logic [DATA_WIDTH-1:0] cfg_max_i,
    input  logic [CNT_WIDTH-1:0]  cfg_high_len_i,
    input  logic [CNT_WIDTH-1:0]  cfg_low_len_i,
    output logic                  cfg_err_o,
    wave_generator_if.master      m
);
    localparam int unsigned SUM_WIDTH = DATA_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] LEN_RESET = CNT_WIDTH'(1) << (CNT_WIDTH - 1);

    typedef enum logic [1:0] {
        MODE_SAW_P  = 2'd0,
        MODE_SAW_N  = 2'd1,
        MODE_TRI    = 2'd2,
        MODE_SQUARE = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef struct packed {
        mode_e                 mode;
        logic [DATA_WIDTH-1:0] step;
        logic [DATA_WIDTH-1:0] min;
        logic [DATA_WIDTH-1:0] max;
        logic [CNT_WIDTH-1:0]  high_len;
        logic [CNT_WIDTH-1:0]  low_len;
    } cfg_t;

    localparam cfg_t CFG_RESET = {MODE_SAW_P, DATA_WIDTH'(1), {DATA_WIDTH{1'b0}},
                                  {DATA_WIDTH{1'b1}}, LEN_RESET, LEN_RESET};

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  first_q, first_d;
    logic                  valid_q, valid_d;
    logic                  dir_q, dir_d;       // tri: 1 = counting down
    logic                  phase_q, phase_d;   // square: 1 = low phase
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;       // square: samples emitted in phase
    cfg_t                  act_q, act_d;
    cfg_t                  pend_q, pend_d;
    logic                  pend_flag_q, pend_flag_d;
    logic                  err_q, err_d;

    logic [SUM_WIDTH-1:0]  sum_up;
    logic [SUM_WIDTH-1:0]  min_plus_step;
    logic [DATA_WIDTH-1:0] diff_dn;
    logic [CNT_WIDTH-1:0]  high_eff, low_eff;
    logic [DATA_WIDTH-1:0] nxt_data;
    logic                  nxt_wrap;
    logic                  nxt_dir, nxt_phase;
    logic [CNT_WIDTH-1:0]  nxt_cnt;
    cfg_t                  new_cfg;
    logic                  restart;

    // Successor of the current sample under the active config; nxt_wrap marks
    // that the next sample starts a new period (start value chosen separately).
    always_comb begin : next_sample
        sum_up        = SUM_WIDTH'(data_q) + SUM_WIDTH'(act_q.step);
        min_plus_step = SUM_WIDTH'(act_q.min) + SUM_WIDTH'(act_q.step);
        diff_dn       = data_q - act_q.step;
        high_eff      = (act_q.high_len == '0) ? CNT_WIDTH'(1) : act_q.high_len;
        low_eff       = (act_q.low_len == '0) ? CNT_WIDTH'(1) : act_q.low_len;
        nxt_data      = data_q;
        nxt_wrap      = 1'b0;
        nxt_dir       = dir_q;
        nxt_phase     = phase_q;
        nxt_cnt       = cnt_q;
        case (act_q.mode)
            MODE_SAW_P: begin
                if (sum_up > SUM_WIDTH'(act_q.max)) nxt_wrap = 1'b1;
                else                                nxt_data = sum_up[DATA_WIDTH-1:0];
            end
            MODE_SAW_N: begin
                if (SUM_WIDTH'(data_q) < min_plus_step) nxt_wrap = 1'b1;
                else                                    nxt_data = diff_dn;
            end
            MODE_TRI: begin
                if (!dir_q) begin
                    if (sum_up >= SUM_WIDTH'(act_q.max)) begin
                        nxt_data = act_q.max;
                        nxt_dir  = 1'b1;
                    end else begin
                        nxt_data = sum_up[DATA_WIDTH-1:0];
                    end
                end else begin
                    if (SUM_WIDTH'(data_q) <= min_plus_step) nxt_wrap = 1'b1;
                    else                                     nxt_data = diff_dn;
                end
            end
            default: begin
                if (!phase_q) begin
                    if (cnt_q < high_eff) begin
                        nxt_cnt = cnt_q + CNT_WIDTH'(1);
                    end else begin
                        nxt_data  = act_q.min;
                        nxt_phase = 1'b1;
                        nxt_cnt   = CNT_WIDTH'(1);
                    end
                end else begin
                    if (cnt_q < low_eff) nxt_cnt = cnt_q + CNT_WIDTH'(1);
                    else                 nxt_wrap = 1'b1;
                end
            end
        endcase
    end

    // FSM next state, handshake, config apply and load handling.
    always_comb begin : next_state
        state_d     = state_q;
        data_d      = data_q;
        first_d     = first_q;
        valid_d     = valid_q;
        dir_d       = dir_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        act_d       = act_q;
        pend_d      = pend_q;
        pend_flag_d = pend_flag_q;
        err_d       = err_q;
        restart     = 1'b0;
        new_cfg     = pend_flag_q ? pend_q : act_q;

        case (state_q)
            ST_IDLE: begin
                if (enable_i) begin
                    restart = 1'b1;
                    state_d = ST_RUN;
                end
            end
            default: begin
                if (valid_q && m.ready) begin
                    if (enable_i) begin
                        if (nxt_wrap) begin
                            restart = 1'b1;
                        end else begin
                            data_d  = nxt_data;
                            first_d = 1'b0;
                            dir_d   = nxt_dir;
                            phase_d = nxt_phase;
                            cnt_d   = nxt_cnt;
                        end
                    end else begin
                        valid_d = 1'b0;
                        first_d = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase

        // Period start: take pending config and emit the start value of its mode.
        if (restart) begin
            act_d       = new_cfg;
            pend_flag_d = 1'b0;
            data_d      = (new_cfg.mode == MODE_SAW_N || new_cfg.mode == MODE_SQUARE) ?
                          new_cfg.max : new_cfg.min;
            first_d     = 1'b1;
            valid_d     = 1'b1;
            dir_d       = 1'b0;
            phase_d     = 1'b0;
            cnt_d       = CNT_WIDTH'(1);
        end

        // Evaluated after the apply so a same-cycle load stays pending.
        if (cfg_load_i) begin
            if (cfg_min_i >= cfg_max_i || cfg_step_i == '0) begin
                err_d = 1'b1;
            end else begin
                pend_d.mode     = mode_e'(cfg_mode_i);
                pend_d.step     = cfg_step_i;
                pend_d.min      = cfg_min_i;
                pend_d.max      = cfg_max_i;
                pend_d.high_len = cfg_high_len_i;
                pend_d.low_len  = cfg_low_len_i;
                pend_flag_d     = 1'b1;
                err_d           = 1'b0;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge a_rst_n_i) begin
        if (!a_rst_n_i) begin
            state_q     <= ST_IDLE;
            data_q      <= '0;
            first_q     <= 1'b0;
            valid_q     <= 1'b0;
            dir_q       <= 1'b0;
            phase_q     <= 1'b0;
            cnt_q       <= CNT_WIDTH'(1);
            act_q       <= CFG_RESET;
            pend_q      <= CFG_RESET;
            pend_flag_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            first_q     <= first_d;
            valid_q     <= valid_d;
            dir_q       <= dir_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            act_q       <= act_d;
            pend_q      <= pend_d;
            pend_flag_q <= pend_flag_d;
            err_q       <= err_d;
        end
    end

    assign cfg_err_o = err_q;
    assign m.data    = data_q;
    assign m.first   = first_q;
    assign m.valid   = valid_q;
endmodule

// File: tb/tb_wave_generator.sv
// Testbench for wave_generator: reference model builds whole waveform periods
// as sample lists and walks them on each transfer; table vectors and short
// directed sequences cover the listed waveforms and corner cases.
module tb_wave_generator;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 16;
    localparam int NV = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          load;
    logic [1:0]    mode;
    logic [DW-1:0] step, mn, mx;
    logic [CW-1:0] hl, ll;
    logic          err;

    wave_generator_if #(.DATA_WIDTH(DW)) s_if ();

    wave_generator #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk_i          (clk),
        .a_rst_n_i      (rst_n),
        .enable_i       (en),
        .cfg_load_i     (load),
        .cfg_mode_i     (mode),
        .cfg_step_i     (step),
        .cfg_min_i      (mn),
        .cfg_max_i      (mx),
        .cfg_high_len_i (hl),
        .cfg_low_len_i  (ll),
        .cfg_err_o      (err),
        .m              (s_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    typedef struct { int mode; int step; int mn; int mx; int hl; int ll; } mcfg_t;
    mcfg_t m_act, m_pend;
    bit    m_pflag, m_err, m_run, m_valid, m_first, need_build;
    int    m_data;
    int    idx;
    int    per[$];
    int    xfer_q[$];

    typedef struct packed {
        logic [1:0]        mode;
        logic [15:0]       step;
        logic [15:0]       mn;
        logic [15:0]       mx;
        logic [15:0]       hl;
        logic [15:0]       ll;
        logic              exp_err;
        logic [0:9][15:0]  seq;
        logic [0:9]        firsts;
    } vec_t;
    vec_t vecs[NV];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One full period of the waveform, straight from the waveform definitions.
    task automatic build_period(input mcfg_t c);
        int v;
        per.delete();
        case (c.mode)
            0: for (v = c.mn; v <= c.mx; v += c.step) per.push_back(v);
            1: for (v = c.mx; v >= c.mn; v -= c.step) per.push_back(v);
            2: begin
                v = c.mn;
                per.push_back(v);
                while (v + c.step < c.mx) begin v += c.step; per.push_back(v); end
                per.push_back(c.mx);
                v = c.mx;
                while (v - c.step > c.mn) begin v -= c.step; per.push_back(v); end
            end
            default: begin
                for (int i = 0; i < ((c.hl == 0) ? 1 : c.hl); i++) per.push_back(c.mx);
                for (int i = 0; i < ((c.ll == 0) ? 1 : c.ll); i++) per.push_back(c.mn);
            end
        endcase
    endtask

    task automatic model_reset();
        m_act      = '{0, 1, 0, 65535, 32768, 32768};
        m_pend     = m_act;
        m_pflag    = 0;
        m_err      = 0;
        m_run      = 0;
        m_valid    = 0;
        m_first    = 0;
        m_data     = 0;
        idx        = 0;
        need_build = 1;
    endtask

    task automatic model_restart();
        if (m_pflag) begin
            m_act      = m_pend;
            m_pflag    = 0;
            need_build = 1;
        end
        if (need_build) begin
            build_period(m_act);
            need_build = 0;
        end
        idx     = 0;
        m_data  = per[0];
        m_first = 1;
        m_valid = 1;
        m_run   = 1;
    endtask

    task automatic model_step();
        if (!m_run) begin
            if (en) model_restart();
        end else if (s_if.ready) begin
            if (en) begin
                idx++;
                if (idx >= per.size()) model_restart();
                else begin
                    m_data  = per[idx];
                    m_first = 0;
                end
            end else begin
                m_run   = 0;
                m_valid = 0;
                m_first = 0;
            end
        end
        if (load) begin
            if (mn >= mx || step == '0) m_err = 1;
            else begin
                m_pend  = '{int'(mode), int'(step), int'(mn), int'(mx), int'(hl), int'(ll)};
                m_pflag = 1;
                m_err   = 0;
            end
        end
    endtask

    // One clock: record transfer, advance model, then compare after the edge.
    task automatic tick();
        if (s_if.valid && s_if.ready) xfer_q.push_back(int'({s_if.first, s_if.data}));
        model_step();
        @(posedge clk);
        #1;
        load = 1'b0;
        chk("valid", int'(s_if.valid), int'(m_valid));
        if (m_valid) begin
            chk("data", int'(s_if.data), m_data);
            chk("first", int'(s_if.first), int'(m_first));
        end
        chk("cfg_err", int'(err), int'(m_err));
    endtask

    task automatic set_cfg(input int md, input int st, input int lo, input int hi,
                           input int h, input int l);
        mode = 2'(md);
        step = 16'(st);
        mn   = 16'(lo);
        mx   = 16'(hi);
        hl   = 16'(h);
        ll   = 16'(l);
    endtask

    task automatic stop_run();
        en = 1'b0;
        s_if.ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            if (!s_if.valid) break;
            tick();
        end
        chk("stop_valid", int'(s_if.valid), 0);
    endtask

    task automatic rand_cfg();
        int base;
        base = ($urandom_range(0, 3) == 0) ? 32'hFF00 : 0;
        mode = 2'($urandom_range(0, 3));
        step = 16'($urandom_range(1, 25));
        mn   = 16'(base + int'($urandom_range(0, 60)));
        mx   = mn + 16'($urandom_range(1, 80));
        if (base != 0 && $urandom_range(0, 1) == 0) mx = 16'hFFFF;
        hl   = 16'($urandom_range(0, 4));
        ll   = 16'($urandom_range(0, 4));
        if ($urandom_range(0, 9) == 0) mx = mn;
        if ($urandom_range(0, 9) == 0) step = '0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        int j;
        vecs[0]  = '{2'd0, 16'd4, 16'd10, 16'd20, 16'd0, 16'd0, 1'b0,
                     {16'd10, 16'd14, 16'd18, 16'd10, 16'd14, 16'd18, 16'd10, 16'd14, 16'd18, 16'd10},
                     10'b1001001001};
        vecs[1]  = '{2'd2, 16'd3, 16'd0, 16'd10, 16'd0, 16'd0, 1'b0,
                     {16'd0, 16'd3, 16'd6, 16'd9, 16'd10, 16'd7, 16'd4, 16'd1, 16'd0, 16'd3},
                     10'b1000000010};
        vecs[2]  = '{2'd3, 16'd1, 16'd5, 16'd9, 16'd2, 16'd3, 1'b0,
                     {16'd9, 16'd9, 16'd5, 16'd5, 16'd5, 16'd9, 16'd9, 16'd5, 16'd5, 16'd5},
                     10'b1000010000};
        vecs[3]  = '{2'd3, 16'd1, 16'd5, 16'd9, 16'd0, 16'd1, 1'b0,
                     {16'd9, 16'd5, 16'd9, 16'd5, 16'd9, 16'd5, 16'd9, 16'd5, 16'd9, 16'd5},
                     10'b1010101010};
        vecs[4]  = '{2'd2, 16'd3, 16'd7, 16'd7, 16'd0, 16'd0, 1'b1, 160'd0, 10'd0};
        vecs[5]  = '{2'd0, 16'h3000, 16'h8000, 16'hFFFF, 16'd0, 16'd0, 1'b0,
                     {16'h8000, 16'hB000, 16'hE000, 16'h8000, 16'hB000, 16'hE000,
                      16'h8000, 16'hB000, 16'hE000, 16'h8000},
                     10'b1001001001};
        vecs[6]  = '{2'd0, 16'd0, 16'd0, 16'd10, 16'd0, 16'd0, 1'b1, 160'd0, 10'd0};
        vecs[7]  = '{2'd1, 16'h7000, 16'h0000, 16'hFFFF, 16'd0, 16'd0, 1'b0,
                     {16'hFFFF, 16'h8FFF, 16'h1FFF, 16'hFFFF, 16'h8FFF, 16'h1FFF,
                      16'hFFFF, 16'h8FFF, 16'h1FFF, 16'hFFFF},
                     10'b1001001001};
        vecs[8]  = '{2'd2, 16'h0800, 16'hF000, 16'hFFFF, 16'd0, 16'd0, 1'b0,
                     {16'hF000, 16'hF800, 16'hFFFF, 16'hF7FF, 16'hF000, 16'hF800,
                      16'hFFFF, 16'hF7FF, 16'hF000, 16'hF800},
                     10'b1000100010};
        vecs[9]  = '{2'd0, 16'd1, 16'd20, 16'd10, 16'd0, 16'd0, 1'b1, 160'd0, 10'd0};
        vecs[10] = '{2'd1, 16'd2, 16'd0, 16'd8, 16'd0, 16'd0, 1'b0,
                     {16'd8, 16'd6, 16'd4, 16'd2, 16'd0, 16'd8, 16'd6, 16'd4, 16'd2, 16'd0},
                     10'b1000010000};
        vecs[11] = '{2'd2, 16'd5, 16'd0, 16'd5, 16'd0, 16'd0, 1'b0,
                     {16'd0, 16'd5, 16'd0, 16'd5, 16'd0, 16'd5, 16'd0, 16'd5, 16'd0, 16'd5},
                     10'b1010101010};

        // Reset state
        rst_n = 1'b1;
        en = 1'b0;
        load = 1'b0;
        s_if.ready = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_valid", int'(s_if.valid), 0);
        chk("rst_first", int'(s_if.first), 0);
        chk("rst_data", int'(s_if.data), 0);
        chk("rst_err", int'(err), 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Defaults: saw-up 0,1,2,... from one cycle after enable
        en = 1'b1;
        s_if.ready = 1'b1;
        for (int k = 0; k < 300; k++) begin
            tick();
            chk("dflt_data", int'(s_if.data), k);
        end

        // Table vectors: load, check reject flag, then run ten samples
        for (int i = 0; i < NV; i++) begin
            stop_run();
            set_cfg(int'(vecs[i].mode), int'(vecs[i].step), int'(vecs[i].mn),
                    int'(vecs[i].mx), int'(vecs[i].hl), int'(vecs[i].ll));
            load = 1'b1;
            tick();
            chk($sformatf("vec%0d_err", i), int'(err), int'(vecs[i].exp_err));
            if (!vecs[i].exp_err) begin
                en = 1'b1;
                for (int k = 0; k < 10; k++) begin
                    tick();
                    chk($sformatf("vec%0d_data%0d", i, k), int'(s_if.data), int'(vecs[i].seq[k]));
                    chk($sformatf("vec%0d_first%0d", i, k), int'(s_if.first), int'(vecs[i].firsts[k]));
                end
            end
        end

        // Mid-run switch tri -> saw_n under random backpressure
        stop_run();
        set_cfg(2, 3, 0, 10, 0, 0);
        load = 1'b1;
        tick();
        en = 1'b1;
        for (int n = 0; n < 7; n++) begin
            s_if.ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        xfer_q.delete();
        set_cfg(1, 2, 0, 8, 0, 0);
        load = 1'b1;
        for (int n = 0; n < 400 && xfer_q.size() < 25; n++) begin
            s_if.ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        chk("sw_count", int'(xfer_q.size() >= 25), 1);
        j = -1;
        for (int n = 0; n < xfer_q.size(); n++) begin
            if (xfer_q[n] == 32'h10008) begin j = n; break; end
        end
        chk("sw_found", int'(j >= 1), 1);
        if (j >= 1 && j + 5 < xfer_q.size()) begin
            chk("sw_prev", xfer_q[j-1], 1);
            chk("sw_s1", xfer_q[j+1], 6);
            chk("sw_s2", xfer_q[j+2], 4);
            chk("sw_s3", xfer_q[j+3], 2);
            chk("sw_s4", xfer_q[j+4], 0);
            chk("sw_s5", xfer_q[j+5], 32'h10008);
        end

        // Random enable/ready/load traffic against the model
        for (int n = 0; n < 2500; n++) begin
            s_if.ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) < 2) en = ~en;
            if ($urandom_range(0, 99) < 4) begin
                rand_cfg();
                load = 1'b1;
            end
            tick();
        end

        // Rejected load leaves the waveform alone; accepted load clears the flag
        stop_run();
        set_cfg(1, 2, 0, 8, 0, 0);
        load = 1'b1;
        tick();
        en = 1'b1;
        tick();
        set_cfg(2, 1, 7, 7, 0, 0);
        load = 1'b1;
        tick();
        chk("rej_err", int'(err), 1);
        for (int n = 0; n < 12; n++) tick();
        set_cfg(0, 1, 0, 5, 0, 0);
        load = 1'b1;
        tick();
        chk("acc_err", int'(err), 0);

        // Enable drop: valid holds while stalled, falls after the transfer
        en = 1'b0;
        s_if.ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("drop_hold", int'(s_if.valid), 1);
        end
        s_if.ready = 1'b1;
        tick();
        chk("drop_fall", int'(s_if.valid), 0);

        // Async reset mid-run drops pending config and outputs at once
        en = 1'b1;
        for (int n = 0; n < 4; n++) tick();
        set_cfg(2, 1, 0, 100, 0, 0);
        load = 1'b1;
        tick();
        set_cfg(0, 1, 9, 9, 0, 0);
        load = 1'b1;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", int'(s_if.valid), 0);
        chk("arst_first", int'(s_if.first), 0);
        chk("arst_data", int'(s_if.data), 0);
        chk("arst_err", int'(err), 0);
        model_reset();
        load = 1'b0;
        en = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        en = 1'b1;
        s_if.ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("arst_restart", int'(s_if.data), k);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
